// File: rtl/pwm_bank.sv
// Multi-channel PWM: shared prescaled period counter (edge/center aligned) driving
// per-channel comparators whose duty/polarity are double-buffered and swapped at the period boundary.

module pwm_lane #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_duty,
  input  logic             wr_inv,
  input  logic [WIDTH-1:0] cnt,
  output logic             out
);

  logic [WIDTH-1:0] duty_sh_q, duty_sh_d, duty_act_q, duty_act_d;
  logic             inv_sh_q, inv_sh_d, inv_act_q, inv_act_d;
  logic             out_q, out_d;

  always_comb begin
    duty_sh_d  = duty_sh_q;
    inv_sh_d   = inv_sh_q;
    duty_act_d = duty_act_q;
    inv_act_d  = inv_act_q;
    if (wr) begin
      duty_sh_d = wr_duty;
      inv_sh_d  = wr_inv;
    end
    // Idle: active tracks the incoming write directly; running: swap only at the
    // boundary, taking the shadow as it stood before any same-cycle write.
    if (!en) begin
      duty_act_d = duty_sh_d;
      inv_act_d  = inv_sh_d;
    end else if (load) begin
      duty_act_d = duty_sh_q;
      inv_act_d  = inv_sh_q;
    end
    out_d = en ? ((cnt < duty_act_q) ^ inv_act_q) : inv_act_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_sh_q  <= '0;
      inv_sh_q   <= 1'b0;
      duty_act_q <= '0;
      inv_act_q  <= 1'b0;
      out_q      <= 1'b0;
    end else begin
      duty_sh_q  <= duty_sh_d;
      inv_sh_q   <= inv_sh_d;
      duty_act_q <= duty_act_d;
      inv_act_q  <= inv_act_d;
      out_q      <= out_d;
    end
  end

  assign out = out_q;

endmodule

module pwm_bank #(
  parameter int NCH     = 4,
  parameter int WIDTH   = 11,
  parameter int PRESC_W = 8,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               center,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [WIDTH-1:0]   period,
  input  logic               wr_en,
  input  logic [CH_W-1:0]    wr_ch,
  input  logic [WIDTH-1:0]   wr_duty,
  input  logic               wr_inv,
  output logic [NCH-1:0]     out,
  output logic               period_start
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DN = 1'b1} dir_t;

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   per_q, per_d;
  dir_t               dir_q, dir_d;
  logic               mode_q, mode_d;
  logic               pend_q, pend_d;
  logic               ps_q, ps_d;
  logic               tick, bnd, load;

  always_comb begin
    presc_cnt_d = presc_cnt_q;
    cnt_d       = cnt_q;
    per_d       = per_q;
    dir_d       = dir_q;
    mode_d      = mode_q;
    pend_d      = 1'b0;
    ps_d        = 1'b0;
    tick        = 1'b0;
    bnd         = 1'b0;
    if (!en) begin
      presc_cnt_d = '0;
      cnt_d       = '0;
      dir_d       = DIR_UP;
      per_d       = period;
      mode_d      = center;
      // Armed so the first out value after enable is flagged as a period start.
      pend_d      = 1'b1;
    end else begin
      tick        = (presc_cnt_q == prescale);
      presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
      // pend marks the first cycle at cnt=0; one more flop lines the pulse up with out.
      ps_d        = pend_q;
      if (tick) begin
        if (per_q == '0) begin
          cnt_d = '0;
          dir_d = DIR_UP;
          bnd   = 1'b1;
        end else if (!mode_q) begin
          dir_d = DIR_UP;
          if (cnt_q >= per_q) begin
            cnt_d = '0;
            bnd   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (dir_q == DIR_UP) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == per_q - 1'b1) dir_d = DIR_DN;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q <= 1) begin
            cnt_d = '0;
            dir_d = DIR_UP;
            bnd   = 1'b1;
          end
        end
        if (bnd) begin
          per_d  = period;
          mode_d = center;
          pend_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt_q <= '0;
      cnt_q       <= '0;
      per_q       <= '0;
      dir_q       <= DIR_UP;
      mode_q      <= 1'b0;
      pend_q      <= 1'b0;
      ps_q        <= 1'b0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      cnt_q       <= cnt_d;
      per_q       <= per_d;
      dir_q       <= dir_d;
      mode_q      <= mode_d;
      pend_q      <= pend_d;
      ps_q        <= ps_d;
    end
  end

  assign load         = tick & bnd;
  assign period_start = ps_q;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    logic wr_sel;
    // Out-of-range channel indices match no lane and are dropped.
    assign wr_sel = wr_en && (wr_ch == CH_W'(i));
    pwm_lane #(.WIDTH(WIDTH)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .load   (load),
      .wr     (wr_sel),
      .wr_duty(wr_duty),
      .wr_inv (wr_inv),
      .cnt    (cnt_q),
      .out    (out[i])
    );
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: per-config waveform table plus hand sequences for
// shadow timing, enable/disable, out-of-range writes and mid-run reset.

module tb_pwm_bank;

  localparam int NCH = 3, WIDTH = 11, PRESC_W = 8, CH_W = 2;

  logic               clk = 1'b0;
  logic               rst, en, center, wr_en, wr_inv;
  logic [PRESC_W-1:0] prescale;
  logic [WIDTH-1:0]   period, wr_duty;
  logic [CH_W-1:0]    wr_ch;
  logic [NCH-1:0]     out;
  logic               period_start;

  int n_chk  = 0;
  int n_fail = 0;

  pwm_bank #(.NCH(NCH), .WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .center      (center),
    .prescale    (prescale),
    .period      (period),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_duty     (wr_duty),
    .wr_inv      (wr_inv),
    .out         (out),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit center;
    int presc;
    int per;
    int duty;
    bit inv;
    int exp_hi;
    int exp_len;
  } row_t;

  row_t rows [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int duty, input bit inv);
    wr_en   = 1'b1;
    wr_ch   = CH_W'(ch);
    wr_duty = WIDTH'(duty);
    wr_inv  = inv;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic wait_ps(input string name);
    int n = 0;
    while (period_start !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    check(name, {31'd0, period_start}, 32'd1);
  endtask

  // Starts on a period_start cycle; counts cycles and high cycles of out[ch]
  // up to the next period_start. Optionally writes a duty when len == wr_at.
  task automatic measure(input int ch, input int wr_at, input int wduty,
                         output int hi, output int len);
    hi  = 0;
    len = 0;
    do begin
      if (len == wr_at) begin
        wr_en   = 1'b1;
        wr_ch   = CH_W'(ch);
        wr_duty = WIDTH'(wduty);
        wr_inv  = 1'b0;
      end
      hi += int'(out[ch]);
      len++;
      step();
      wr_en = 1'b0;
    end while (period_start !== 1'b1 && len < 200);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, len;
    //          ctr presc per duty inv  hi  len
    rows[0]  = '{1'b0, 0, 9,  3, 1'b0,  3, 10};
    rows[1]  = '{1'b1, 0, 4,  2, 1'b0,  3,  8};
    rows[2]  = '{1'b1, 2, 4,  2, 1'b0,  9, 24};
    rows[3]  = '{1'b0, 0, 9,  0, 1'b0,  0, 10};
    rows[4]  = '{1'b0, 0, 9, 10, 1'b0, 10, 10};
    rows[5]  = '{1'b0, 0, 9,  0, 1'b1, 10, 10};
    rows[6]  = '{1'b0, 0, 0,  1, 1'b0,  1,  1};
    rows[7]  = '{1'b0, 2, 0,  0, 1'b1,  3,  3};
    rows[8]  = '{1'b0, 1, 3,  2, 1'b0,  4,  8};
    rows[9]  = '{1'b1, 0, 4,  4, 1'b0,  7,  8};
    rows[10] = '{1'b1, 0, 4,  2, 1'b1,  5,  8};
    rows[11] = '{1'b1, 0, 1,  1, 1'b0,  1,  2};

    rst = 1'b1; en = 1'b0; center = 1'b0; prescale = '0; period = '0;
    wr_en = 1'b0; wr_ch = '0; wr_duty = '0; wr_inv = 1'b0;
    repeat (3) step();
    check("reset_out", {29'd0, out}, 32'd0);
    check("reset_ps", {31'd0, period_start}, 32'd0);
    rst = 1'b0;
    step();

    for (int r = 0; r < 12; r++) begin
      en       = 1'b0;
      center   = rows[r].center;
      prescale = PRESC_W'(rows[r].presc);
      period   = WIDTH'(rows[r].per);
      wr(0, rows[r].duty, rows[r].inv);
      step();
      en = 1'b1;
      wait_ps($sformatf("row%0d_start", r));
      for (int k = 0; k < 2; k++) begin
        measure(0, -1, 0, hi, len);
        check($sformatf("row%0d_p%0d_high", r, k), hi, rows[r].exp_hi);
        check($sformatf("row%0d_p%0d_len", r, k), len, rows[r].exp_len);
      end
    end

    // Shadow timing: mid-period write, then write on the boundary cycle.
    en = 1'b0; center = 1'b0; prescale = '0; period = 11'd9;
    wr(1, 2, 1'b0);
    en = 1'b1;
    wait_ps("shadow_start");
    measure(1, 3, 7, hi, len);
    check("mid_write_old_high", hi, 2);
    check("mid_write_len", len, 10);
    measure(1, -1, 0, hi, len);
    check("mid_write_new_high", hi, 7);
    measure(1, 8, 4, hi, len);
    check("bnd_write_cur_high", hi, 7);
    measure(1, -1, 0, hi, len);
    check("bnd_write_next_high", hi, 7);
    measure(1, -1, 0, hi, len);
    check("bnd_write_later_high", hi, 4);

    // Enable / disable behaviour with mixed polarity.
    en = 1'b0;
    wr(0, 3, 1'b0);
    wr(1, 4, 1'b1);
    wr(2, 0, 1'b1);
    step();
    check("idle_out", {29'd0, out}, 32'b110);
    en = 1'b1;
    step();
    check("en_rise_ps", {31'd0, period_start}, 32'd1);
    check("en_rise_out", {29'd0, out}, 32'b101);
    repeat (4) step();
    en = 1'b0;
    step();
    check("en_fall_out", {29'd0, out}, 32'b110);
    check("en_fall_ps", {31'd0, period_start}, 32'd0);
    step();
    check("en_low_hold_out", {29'd0, out}, 32'b110);

    // Out-of-range channel write must not touch any lane.
    wr(0, 3, 1'b0);
    wr(1, 4, 1'b0);
    wr(2, 0, 1'b0);
    step();
    check("oor_pre_out", {29'd0, out}, 32'd0);
    wr(3, 5, 1'b1);
    step();
    check("oor_post_out", {29'd0, out}, 32'd0);
    en = 1'b1;
    wait_ps("oor_start");
    measure(0, -1, 0, hi, len);
    check("oor_ch0_high", hi, 3);
    measure(1, -1, 0, hi, len);
    check("oor_ch1_high", hi, 4);
    measure(2, -1, 0, hi, len);
    check("oor_ch2_high", hi, 0);

    // Reset mid-period, then a write landing on the first post-reset boundary.
    repeat (4) step();
    rst = 1'b1;
    step();
    check("midrst_out", {29'd0, out}, 32'd0);
    check("midrst_ps", {31'd0, period_start}, 32'd0);
    rst = 1'b0;
    wr(0, 3, 1'b0);
    wait_ps("midrst_start");
    measure(0, -1, 0, hi, len);
    check("midrst_p0_high", hi, 0);
    check("midrst_p0_len", len, 10);
    measure(0, -1, 0, hi, len);
    check("midrst_p1_high", hi, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
